// File: rtl/backpack_pkg.sv
// Shared knapsack geometry and the traceback FSM state encoding.
// The DP engine uses the same geometry so both blocks agree on the table size.
package backpack_pkg;

  localparam int unsigned BAG_SIZE_DEF     = 8;
  localparam int unsigned GOODS_NUMBER_DEF = 4;
  localparam int unsigned W_W_DEF          = 10;
  localparam int unsigned VAL_W_DEF        = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_TOP,
    WAIT_TOP,
    RD_ITEM,
    CMP,
    DONE
  } tb_state_e;

endpackage

// File: rtl/backpack_traceback.sv
// Walks the finished knapsack DP table back from dp[GOODS_NUMBER][BAG_SIZE]
// and reports the optimum value, the chosen-item mask and the total weight.
import backpack_pkg::*;

module backpack_traceback #(
  parameter int unsigned BAG_SIZE     = BAG_SIZE_DEF,
  parameter int unsigned GOODS_NUMBER = GOODS_NUMBER_DEF,
  parameter int unsigned W_W          = W_W_DEF,
  parameter int unsigned VAL_W        = VAL_W_DEF
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    start,
  output logic                    dp_rd_en,
  output logic [W_W-1:0]          dp_rd_i,
  output logic [W_W-1:0]          dp_rd_j,
  input  logic [VAL_W-1:0]        dp_rd_data,
  output logic [W_W-1:0]          item_idx,
  input  logic [W_W-1:0]          item_weight,
  input  logic [W_W-1:0]          item_value,
  output logic                    busy,
  output logic                    done,
  output logic [VAL_W-1:0]        max_value,
  output logic [GOODS_NUMBER-1:0] sel_mask,
  output logic [W_W-1:0]          used_weight,
  output logic                    err
);

  tb_state_e               state_q;
  logic [VAL_W-1:0]        cur_q;
  logic [W_W-1:0]          i_q;
  logic [W_W-1:0]          j_q;
  logic                    busy_q;
  logic                    done_q;
  logic [VAL_W-1:0]        max_value_q;
  logic [GOODS_NUMBER-1:0] sel_mask_q;
  logic [W_W-1:0]          used_weight_q;
  logic                    err_q;

  logic [GOODS_NUMBER-1:0] sel_bit;
  logic [W_W:0]            uw_sum;
  logic [W_W-1:0]          uw_sat;

  // One-hot of item i, avoids a variable bit-select with a wide index.
  always_comb begin
    sel_bit = '0;
    for (int unsigned k = 0; k < GOODS_NUMBER; k++) begin
      sel_bit[k] = (i_q == W_W'(k + 1));
    end
  end

  assign uw_sum = {1'b0, used_weight_q} + {1'b0, item_weight};
  assign uw_sat = uw_sum[W_W] ? '1 : uw_sum[W_W-1:0];

  always_comb begin
    dp_rd_en = 1'b0;
    dp_rd_i  = '0;
    dp_rd_j  = '0;
    item_idx = '0;
    case (state_q)
      RD_TOP: begin
        dp_rd_en = 1'b1;
        dp_rd_i  = W_W'(GOODS_NUMBER);
        dp_rd_j  = W_W'(BAG_SIZE);
      end
      RD_ITEM: begin
        dp_rd_en = 1'b1;
        dp_rd_i  = i_q - W_W'(1);
        dp_rd_j  = j_q;
        item_idx = i_q;
      end
      CMP:     item_idx = i_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      i_q           <= '0;
      j_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      max_value_q   <= '0;
      sel_mask_q    <= '0;
      used_weight_q <= '0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_mask_q    <= '0;
            used_weight_q <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= RD_TOP;
          end
        end
        RD_TOP:   state_q <= WAIT_TOP;
        WAIT_TOP: begin
          cur_q       <= dp_rd_data;
          max_value_q <= dp_rd_data;
          i_q         <= W_W'(GOODS_NUMBER);
          j_q         <= W_W'(BAG_SIZE);
          state_q     <= RD_ITEM;
        end
        RD_ITEM:  state_q <= CMP;
        CMP: begin
          if (dp_rd_data != cur_q) begin
            if (item_weight <= j_q) begin
              sel_mask_q    <= sel_mask_q | sel_bit;
              j_q           <= j_q - item_weight;
              used_weight_q <= uw_sat;
              cur_q         <= cur_q - VAL_W'(item_value);
            end else begin
              err_q <= 1'b1;
              cur_q <= dp_rd_data;
            end
          end else begin
            cur_q <= dp_rd_data;
          end
          if (i_q == W_W'(1)) begin
            state_q <= DONE;
          end else begin
            i_q     <= i_q - W_W'(1);
            state_q <= RD_ITEM;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign max_value   = max_value_q;
  assign sel_mask    = sel_mask_q;
  assign used_weight = used_weight_q;
  assign err         = err_q;

endmodule

// File: tb/tb_backpack_traceback.sv
// Directed bench: models the DP table and item tables, scoreboards the results.
module tb_backpack_traceback;

  logic        clk;
  logic        res;
  logic        start;
  logic        dp_rd_en;
  logic [9:0]  dp_rd_i;
  logic [9:0]  dp_rd_j;
  logic [15:0] dp_rd_data;
  logic [9:0]  item_idx;
  logic [9:0]  item_weight;
  logic [9:0]  item_value;
  logic        busy;
  logic        done;
  logic [15:0] max_value;
  logic [3:0]  sel_mask;
  logic [9:0]  used_weight;
  logic        err;

  typedef struct packed {
    logic [15:0] mv;
    logic [3:0]  mask;
    logic [9:0]  uw;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] dp [0:4][0:8];
  logic [9:0]  wt [1:4];
  logic [9:0]  vl [1:4];

  // Expected read sequence for the first scenario, indexed by cycle after start.
  bit       seq_en [0:11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  int       seq_ri [0:11] = '{4, 0, 3, 0, 2, 0, 1, 0, 0, 0, 0, 0};
  int       seq_rj [0:11] = '{8, 0, 8, 0, 3, 0, 3, 0, 0, 0, 0, 0};

  backpack_traceback #(
    .BAG_SIZE(8),
    .GOODS_NUMBER(4),
    .W_W(10),
    .VAL_W(16)
  ) dut (
    .clk(clk),
    .res(res),
    .start(start),
    .dp_rd_en(dp_rd_en),
    .dp_rd_i(dp_rd_i),
    .dp_rd_j(dp_rd_j),
    .dp_rd_data(dp_rd_data),
    .item_idx(item_idx),
    .item_weight(item_weight),
    .item_value(item_value),
    .busy(busy),
    .done(done),
    .max_value(max_value),
    .sel_mask(sel_mask),
    .used_weight(used_weight),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dp_rd_en) begin
      if (dp_rd_i <= 10'd4 && dp_rd_j <= 10'd8) dp_rd_data <= dp[dp_rd_i[2:0]][dp_rd_j[3:0]];
      else dp_rd_data <= 16'hdead;
    end
  end

  always_comb begin
    item_weight = '0;
    item_value  = '0;
    for (int k = 1; k <= 4; k++) begin
      if (item_idx == 10'(k)) begin
        item_weight = wt[k];
        item_value  = vl[k];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_items(input int w1, input int w2, input int w3, input int w4,
                           input int v1, input int v2, input int v3, input int v4);
    wt[1] = 10'(w1); wt[2] = 10'(w2); wt[3] = 10'(w3); wt[4] = 10'(w4);
    vl[1] = 10'(v1); vl[2] = 10'(v2); vl[3] = 10'(v3); vl[4] = 10'(v4);
  endtask

  // Standard 0/1 knapsack fill, standing in for the upstream DP engine.
  task automatic build_dp();
    int best;
    int alt;
    for (int i = 0; i <= 4; i++) begin
      for (int j = 0; j <= 8; j++) begin
        if (i == 0) begin
          dp[i][j] = '0;
        end else begin
          best = int'(dp[i-1][j]);
          if (int'(wt[i]) <= j) begin
            alt = int'(dp[i-1][j - int'(wt[i])]) + int'(vl[i]);
            if (alt > best) best = alt;
          end
          dp[i][j] = 16'(best);
        end
      end
    end
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_max_value"}, 32'(max_value), 32'(e.mv));
      chk({tag, "_sel_mask"}, 32'(sel_mask), 32'(e.mask));
      chk({tag, "_used_weight"}, 32'(used_weight), 32'(e.uw));
      chk({tag, "_err"}, 32'(err), 32'(e.err));
    end
  endtask

  task automatic run(input string tag, input exp_t e, input bit seq, input int repulse);
    bit seen;
    seen = 1'b0;
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (seq && k <= 11) begin
        chk($sformatf("%s_rd_en_%0d", tag, k), 32'(dp_rd_en), 32'(seq_en[k]));
        if (seq_en[k]) begin
          chk($sformatf("%s_rd_i_%0d", tag, k), 32'(dp_rd_i), 32'(seq_ri[k]));
          chk($sformatf("%s_rd_j_%0d", tag, k), 32'(dp_rd_j), 32'(seq_rj[k]));
        end
      end
      if (done) begin
        seen = 1'b1;
        chk({tag, "_latency"}, 32'(k), 32'd11);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        compare_result(tag);
        break;
      end
      start = (k == repulse);
      tick();
    end
    start = 1'b0;
    if (!seen) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  exp_t e1, e2, e3, e4;
  int   ndone;

  initial begin
    res   = 1'b1;
    start = 1'b0;
    e1 = '{16'd10, 4'b1010, 10'd8, 1'b0};
    e2 = '{16'd0,  4'b0000, 10'd0, 1'b0};
    e3 = '{16'd10, 4'b1111, 10'd4, 1'b0};
    e4 = '{16'd10, 4'b0110, 10'd7, 1'b1};
    set_items(2, 3, 4, 5, 3, 4, 5, 6);
    build_dp();
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_max_value", 32'(max_value), 32'd0);
    chk("rst_sel_mask", 32'(sel_mask), 32'd0);
    chk("rst_used_weight", 32'(used_weight), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_en", 32'(dp_rd_en), 32'd0);
    chk("rst_item_idx", 32'(item_idx), 32'd0);
    res = 1'b0;
    tick();

    run("basic", e1, 1'b1, -1);

    set_items(9, 9, 9, 9, 7, 1, 5, 3);
    build_dp();
    run("heavy", e2, 1'b0, -1);

    set_items(1, 1, 1, 1, 1, 2, 3, 4);
    build_dp();
    run("light", e3, 1'b0, -1);

    set_items(2, 3, 4, 5, 3, 4, 5, 6);
    build_dp();
    wt[4]    = 10'd9;
    dp[3][8] = 16'd0;
    run("corrupt", e4, 1'b0, -1);
    chk("corrupt_bit3_clear", 32'(sel_mask[3]), 32'd0);

    set_items(2, 3, 4, 5, 3, 4, 5, 6);
    build_dp();
    run("repulse", e1, 1'b1, 3);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("repulse_no_extra_done", 32'(ndone), 32'd0);
    chk("repulse_idle_busy", 32'(busy), 32'd0);

    // Start held high: one run per IDLE visit, done every 12 cycles.
    ndone = 0;
    repeat (3) sb.push_back(e1);
    start = 1'b1;
    tick();
    for (int k = 0; k <= 35; k++) begin
      chk($sformatf("held_done_%0d", k), 32'(done), 32'((k % 12) == 11));
      if (done) begin
        ndone++;
        compare_result("held");
      end
      if (k == 35) start = 1'b0;
      else tick();
    end
    chk("held_done_count", 32'(ndone), 32'd3);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("held_no_trailing_done", 32'(ndone), 32'd0);

    // Reset in the middle of the run, during CMP of item 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("midres_item_idx", 32'(item_idx), 32'd3);
    chk("midres_rd_en", 32'(dp_rd_en), 32'd0);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("midres_busy", 32'(busy), 32'd0);
    chk("midres_done", 32'(done), 32'd0);
    chk("midres_max_value", 32'(max_value), 32'd0);
    chk("midres_sel_mask", 32'(sel_mask), 32'd0);
    chk("midres_used_weight", 32'(used_weight), 32'd0);
    chk("midres_err", 32'(err), 32'd0);
    chk("midres_rd_en_idle", 32'(dp_rd_en), 32'd0);
    chk("midres_item_idx_idle", 32'(item_idx), 32'd0);
    tick();
    run("after_res", e1, 1'b1, -1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/backpack_traceback.md
Name: backpack_traceback

Overview:
- Downstream stage of the 0/1 knapsack DP engine; consumes the finished dp[i][j] table plus the item weight/value tables.
- Walks back from dp[GOODS_NUMBER][BAG_SIZE] to reconstruct which items form the optimum.
- Reports max_value, a per-item selection mask and the total weight used.
- Runs once per start pulse, with fixed latency.

Parameters:
- BAG_SIZE, 8, knapsack capacity (column count minus 1)
- GOODS_NUMBER, 4, item count (row count minus 1)
- W_W, 10, width of weight/value/index fields
- VAL_W, 16, width of dp entries

Ports:
- clk  in  1  system clock
- res  in  1  synchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- dp_rd_en  out  1  dp table read strobe
- dp_rd_i  out  W_W  dp row address
- dp_rd_j  out  W_W  dp column address
- dp_rd_data  in  VAL_W  dp[dp_rd_i][dp_rd_j], valid one cycle after dp_rd_en
- item_idx  out  W_W  item-table address, combinational lookup
- item_weight  in  W_W  weight[item_idx], same cycle
- item_value  in  W_W  value[item_idx], same cycle
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; results valid from this cycle on
- max_value  out  VAL_W  dp[GOODS_NUMBER][BAG_SIZE]
- sel_mask  out  GOODS_NUMBER  bit k-1 set means item k is chosen
- used_weight  out  W_W  sum of chosen weights
- err  out  1  inconsistent table detected during the last run

Behaviour:
- Clock and reset: one clock (clk); res is synchronous, active-high. res forces IDLE, including mid-run.
- Reset values: every output is 0, and internal cur, i and j are 0.
- States: IDLE, RD_TOP, WAIT_TOP, RD_ITEM, CMP, DONE.
- IDLE: on start, clear sel_mask, used_weight and err, assert busy, go to RD_TOP. Start is ignored in every other state.
- RD_TOP: dp_rd_en=1 with address (GOODS_NUMBER, BAG_SIZE). Go to WAIT_TOP.
- WAIT_TOP: cur <= dp_rd_data, max_value <= dp_rd_data, i <= GOODS_NUMBER, j <= BAG_SIZE. Go to RD_ITEM.
- RD_ITEM: dp_rd_en=1 with address (i-1, j); item_idx=i. Go to CMP.
- CMP: item_idx=i, and let r = dp_rd_data.
  - If r != cur and item_weight <= j: set sel_mask[i-1], j <= j - item_weight, used_weight += item_weight, cur <= cur - item_value.
  - If r != cur and item_weight > j: set err, item not selected, cur <= r.
  - If r == cur: item not selected, cur <= r.
  - If i==1, go to DONE. Otherwise i <= i-1 and go to RD_ITEM.
- DONE: done=1 for one cycle, busy <= 0, go to IDLE.
- Latency is fixed: done rises 2*GOODS_NUMBER+3 cycles after the edge that samples start (11 cycles for defaults). It does not short-circuit when j or cur reaches 0.
- dp_rd_en is 0 outside RD_TOP and RD_ITEM; addresses are don't-care when dp_rd_en is 0.
- Results hold until the next accepted start or res.
- Arithmetic: the j subtraction is guarded, so j never wraps. Subtraction on cur truncates to VAL_W. used_weight saturates at 2^W_W-1.
- The caller guarantees the dp table is stable from start to done; the block does not check this.

Decomposition:
- Shared package backpack_pkg holds:
  - the state encoding constants;
  - BAG_SIZE, GOODS_NUMBER, W_W and VAL_W defaults, shared with the DP engine so table geometry matches.
- No sub-module is needed; a single FSM plus datapath is expected (~150–200 lines).

Test Plan:
- Defaults; weights 2,3,4,5; values 3,4,5,6; converged table; start -> done at +11 cycles, max_value=10, sel_mask=4'b1010, used_weight=8, err=0.
- All weights 9 (exceed capacity), values arbitrary -> max_value=0, sel_mask=0, used_weight=0, err=0.
- Weights 1,1,1,1; values 1,2,3,4 -> max_value=10, sel_mask=4'b1111, used_weight=4.
- Corrupt dp[3][8] to 0 with top=10, weight[4]=9 -> err=1, bit 3 clear.
- Start pulsed again while busy, plus start held high -> second request ignored, exactly one done per accepted start; check the dp_rd_en/address sequence cycle by cycle.
- res asserted during CMP of item 3 -> next cycle IDLE, busy=0, all outputs 0; a fresh start then reproduces the first scenario.
